// File: rtl/uart_bcd_transmitter.sv
// uart_bcd_transmitter: sends a two-digit BCD value as ASCII "TU\r\n" over an 8N1 UART.
// Each request produces one complete line, and characters are sent back to back.
module uart_bcd_transmitter #(
  parameter int BAUD_DIV = 434
) (
  input  logic       CLOCK_50_I,
  input  logic       resetn,
  input  logic [7:0] bcd_value,
  input  logic       send_req,
  output logic       busy,
  output logic       tx_done,
  output logic       UART_TX_O
);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  localparam logic [15:0] BMAX = 16'(BAUD_DIV - 1);
  state_t      state_q, state_d;
  logic [7:0]  val_q, val_d;
  logic [1:0]  idx_q, idx_d;
  logic [2:0]  bit_q, bit_d;
  logic [15:0] baud_q, baud_d;
  logic [7:0]  shift_q, shift_d;
  logic        tx_q, tx_d;
  logic        done_q, done_d;
  logic        baud_end;
  // Nibbles 10..15 become 'A'..'F', so non-BCD input shows up on the terminal.
  function automatic logic [7:0] char_of(input logic [1:0] i, input logic [7:0] v);
    logic [3:0] n;
    n = i[0] ? v[3:0] : v[7:4];
    return i[1] ? (i[0] ? 8'h0A : 8'h0D)
                : (n < 4'd10 ? 8'h30 + {4'h0, n} : 8'h37 + {4'h0, n});
  endfunction
  always_comb begin
    state_d  = state_q;
    val_d    = val_q;
    idx_d    = idx_q;
    bit_d    = bit_q;
    baud_d   = baud_q;
    shift_d  = shift_q;
    tx_d     = tx_q;
    done_d   = 1'b0;
    baud_end = baud_q == BMAX;
    if (state_q != IDLE) baud_d = baud_end ? 16'd0 : baud_q + 16'd1;
    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (send_req) begin
          state_d = START;
          val_d   = bcd_value;
          idx_d   = 2'd0;
          bit_d   = 3'd0;
          baud_d  = 16'd0;
          shift_d = char_of(2'd0, bcd_value);
          tx_d    = 1'b0;
        end
      end
      START: if (baud_end) begin
        state_d = DATA;
        bit_d   = 3'd0;
        tx_d    = shift_q[0];
        shift_d = {1'b0, shift_q[7:1]};
      end
      DATA: if (baud_end) begin
        if (bit_q == 3'd7) begin
          state_d = STOP;
          tx_d    = 1'b1;
        end else begin
          bit_d   = bit_q + 3'd1;
          tx_d    = shift_q[0];
          shift_d = {1'b0, shift_q[7:1]};
        end
      end
      STOP: if (baud_end) begin
        if (idx_q != 2'd3) begin
          state_d = START;
          idx_d   = idx_q + 2'd1;
          shift_d = char_of(idx_q + 2'd1, val_q);
          tx_d    = 1'b0;
        end else begin
          state_d = IDLE;
          done_d  = 1'b1;
          tx_d    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge CLOCK_50_I or negedge resetn)
    if (!resetn) begin
      state_q <= IDLE;
      val_q   <= 8'h00;
      idx_q   <= 2'd0;
      bit_q   <= 3'd0;
      baud_q  <= 16'd0;
      shift_q <= 8'h00;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      val_q   <= val_d;
      idx_q   <= idx_d;
      bit_q   <= bit_d;
      baud_q  <= baud_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
    end
  assign busy      = state_q != IDLE;
  assign tx_done   = done_q;
  assign UART_TX_O = tx_q;
endmodule
